// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU: fetch/decode/exec/mem/wb sequencing.
// Optional retired-instruction counter enabled by defining CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int COUNT_W      = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       ir_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic       ext_zero,
    output logic [1:0] fault,
    output logic       busy
`ifdef CTRL_PERF_EN
    ,
    output logic [COUNT_W-1:0] retired
`endif
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3;
    localparam logic [1:0] FAULT_NONE = 2'd0, FAULT_ILLEGAL = 2'd1, FAULT_MEM = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [1:0]        fault_reg, fault_next;

    if (COUNT_W < 1) begin : g_bad_count_w
        $error("COUNT_W must be at least 1");
    end

    logic is_rtype, is_j, is_jal, is_bne, is_addi, is_xori, is_lw, is_sw;
    logic r_add, r_sub, r_slt, r_jr, legal, wait_limit;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign is_bne   = (opcode == OP_BNE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_xori  = (opcode == OP_XORI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign r_add    = is_rtype && (funct == FN_ADD);
    assign r_sub    = is_rtype && (funct == FN_SUB);
    assign r_slt    = is_rtype && (funct == FN_SLT);
    assign r_jr     = is_rtype && (funct == FN_JR);
    assign legal    = r_add || r_sub || r_slt || r_jr || is_j || is_jal || is_bne
                   || is_addi || is_xori || is_lw || is_sw;

    // True on the MEM_WAIT_MAX-th consecutive waiting cycle; a mem_ready in that cycle still wins.
    assign wait_limit = (MEM_WAIT_MAX != 0) && (wait_reg == WAIT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
            fault_reg <= FAULT_NONE;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        fault_next   = fault_reg;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        ir_we        = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = 2'd0;
        wb_sel       = 2'd0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        ext_zero     = 1'b0;
        busy         = 1'b1;
        // Gating on rst_n keeps every request quiet from the instant reset falls.
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        state_next = S_DECODE;
                    end else if (wait_limit) begin
                        fault_next = FAULT_MEM;
                        state_next = S_HALT;
                    end else begin
                        wait_next = wait_reg + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    ext_zero = is_xori;
                    if (!legal) begin
                        fault_next = FAULT_ILLEGAL;
                        state_next = S_HALT;
                    end else if (is_j || is_jal) begin
                        pc_we      = 1'b1;
                        pc_sel     = 2'd2;
                        reg_we     = is_jal;
                        reg_dst    = is_jal ? 2'd2 : 2'd0;
                        wb_sel     = is_jal ? 2'd2 : 2'd0;
                        state_next = S_FETCH;
                    end else if (r_jr) begin
                        pc_we      = 1'b1;
                        pc_sel     = 2'd3;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_rtype) begin
                        alu_op = r_sub ? ALU_SUB : (r_slt ? ALU_SLT : ALU_ADD);
                    end else if (is_bne) begin
                        alu_op = ALU_SUB;
                    end else begin
                        alu_src_b = 1'b1;
                        alu_op    = is_xori ? ALU_XOR : ALU_ADD;
                    end
                    if (is_bne) begin
                        pc_we      = !alu_zero;
                        pc_sel     = alu_zero ? 2'd0 : 2'd1;
                        state_next = S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state_next = S_MEM;
                    end else begin
                        state_next = S_WB;
                    end
                end
                S_MEM: begin
                    mem_addr_sel = 1'b1;
                    mem_re       = is_lw;
                    mem_we       = is_sw;
                    if (mem_ready) begin
                        state_next = is_lw ? S_WB : S_FETCH;
                    end else if (wait_limit) begin
                        fault_next = FAULT_MEM;
                        state_next = S_HALT;
                    end else begin
                        wait_next = wait_reg + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = is_rtype ? 2'd1 : 2'd0;
                    wb_sel     = is_lw ? 2'd1 : 2'd0;
                    state_next = S_FETCH;
                end
                default: busy = 1'b0;
            endcase
            if (state_next != state_reg) wait_next = '0;
        end
    end

    assign fault = fault_reg;

`ifdef CTRL_PERF_EN
    logic [COUNT_W-1:0] retired_reg;

    // Only successful completions return to FETCH; faults go to HALT and are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= '0;
        end else if (state_reg != S_FETCH && state_next == S_FETCH) begin
            retired_reg <= retired_reg + COUNT_W'(1);
        end
    end

    assign retired = retired_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven, scoreboard-checked bench for multicycle_ctrl (built with MEM_WAIT_MAX = 4).
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       busy;
        logic [1:0] fault;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ir_we;
        logic       mem_re;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_zero;
    } outs_t;

    typedef struct {
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       alu_zero;
        logic       mem_ready;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic alu_zero = 1'b0, mem_ready = 1'b0;
    logic pc_we, ir_we, mem_re, mem_we, mem_addr_sel, reg_we, alu_src_b, ext_zero, busy;
    logic [1:0] pc_sel, reg_dst, wb_sel, fault;
    logic [2:0] alu_op;
`ifdef CTRL_PERF_EN
    logic [31:0] retired;
`endif

    int checks = 0;
    int errors = 0;
    outs_t exp_q[$];
    vec_t  vecs[$];

    outs_t RST, F_RDY, F_WAIT, B, EX_IMM, WB_RT, WB_RD;

    always #5 clk = ~clk;

    multicycle_ctrl #(.COUNT_W(32), .MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .mem_re(mem_re),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .reg_we(reg_we),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .ext_zero(ext_zero), .fault(fault), .busy(busy)
`ifdef CTRL_PERF_EN
        , .retired(retired)
`endif
    );

    function automatic vec_t v(input logic [5:0] op, input logic [5:0] fn,
                               input logic az, input logic rdy, input outs_t e);
        vec_t r;
        r.opcode = op; r.funct = fn; r.alu_zero = az; r.mem_ready = rdy; r.exp = e;
        return r;
    endfunction

    task automatic compare(input int id);
        outs_t got, want;
        got = {busy, fault, pc_we, pc_sel, ir_we, mem_re, mem_we, mem_addr_sel,
               reg_we, reg_dst, wb_sel, alu_src_b, alu_op, ext_zero};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d: outputs got %05h expected %05h", id, got, want);
        end else begin
            $display("step %0d ok: outputs %05h", id, got);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check, then let one rising edge pass.
    task automatic step(input vec_t x, input int id);
        opcode = x.opcode; funct = x.funct; alu_zero = x.alu_zero; mem_ready = x.mem_ready;
        exp_q.push_back(x.exp);
        #1 compare(id);
        @(negedge clk);
    endtask

    task automatic do_reset(input int id);
        rst_n = 1'b0;
        opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        exp_q.push_back(RST);
        #1 compare(id);
`ifdef CTRL_PERF_EN
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL retired_reset: got %0d expected 0", retired);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        RST    = '{busy: 1'b1, default: '0};
        B      = '{busy: 1'b1, default: '0};
        F_RDY  = '{busy: 1'b1, mem_re: 1'b1, ir_we: 1'b1, pc_we: 1'b1, default: '0};
        F_WAIT = '{busy: 1'b1, mem_re: 1'b1, default: '0};
        EX_IMM = '{busy: 1'b1, alu_src_b: 1'b1, default: '0};
        WB_RT  = '{busy: 1'b1, reg_we: 1'b1, default: '0};
        WB_RD  = '{busy: 1'b1, reg_we: 1'b1, reg_dst: 2'd1, default: '0};

        // ADD, SUB, SLT
        vecs.push_back(v(6'h00, 6'h20, 0, 1, F_RDY));
        vecs.push_back(v(6'h00, 6'h20, 0, 1, B));
        vecs.push_back(v(6'h00, 6'h20, 0, 1, B));
        vecs.push_back(v(6'h00, 6'h20, 0, 1, WB_RD));
        vecs.push_back(v(6'h00, 6'h22, 0, 1, F_RDY));
        vecs.push_back(v(6'h00, 6'h22, 0, 1, B));
        vecs.push_back(v(6'h00, 6'h22, 0, 1, '{busy: 1'b1, alu_op: 3'd1, default: '0}));
        vecs.push_back(v(6'h00, 6'h22, 0, 1, WB_RD));
        vecs.push_back(v(6'h00, 6'h2A, 0, 1, F_RDY));
        vecs.push_back(v(6'h00, 6'h2A, 0, 1, B));
        vecs.push_back(v(6'h00, 6'h2A, 0, 1, '{busy: 1'b1, alu_op: 3'd3, default: '0}));
        vecs.push_back(v(6'h00, 6'h2A, 0, 1, WB_RD));
        // XORI / ADDI with imm 0x8000 (funct field = imm[5:0] = 0)
        vecs.push_back(v(6'h0E, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h0E, 6'h00, 0, 1, '{busy: 1'b1, ext_zero: 1'b1, default: '0}));
        vecs.push_back(v(6'h0E, 6'h00, 0, 1, '{busy: 1'b1, alu_src_b: 1'b1, alu_op: 3'd2, default: '0}));
        vecs.push_back(v(6'h0E, 6'h00, 0, 1, WB_RT));
        vecs.push_back(v(6'h08, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h08, 6'h00, 0, 1, B));
        vecs.push_back(v(6'h08, 6'h00, 0, 1, EX_IMM));
        vecs.push_back(v(6'h08, 6'h00, 0, 1, WB_RT));
        // LW with three extra wait cycles in MEM (8 cycles total)
        vecs.push_back(v(6'h23, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h23, 6'h00, 0, 1, B));
        vecs.push_back(v(6'h23, 6'h00, 0, 1, EX_IMM));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(6'h23, 6'h00, 0, (i == 3),
                             '{busy: 1'b1, mem_re: 1'b1, mem_addr_sel: 1'b1, default: '0}));
        vecs.push_back(v(6'h23, 6'h00, 0, 1, '{busy: 1'b1, reg_we: 1'b1, wb_sel: 2'd1, default: '0}));
        // SW
        vecs.push_back(v(6'h2B, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h2B, 6'h00, 0, 1, B));
        vecs.push_back(v(6'h2B, 6'h00, 0, 1, EX_IMM));
        vecs.push_back(v(6'h2B, 6'h00, 0, 1, '{busy: 1'b1, mem_we: 1'b1, mem_addr_sel: 1'b1, default: '0}));
        // BNE taken / not taken
        vecs.push_back(v(6'h05, 6'h00, 1, 1, F_RDY));
        vecs.push_back(v(6'h05, 6'h00, 1, 1, B));
        vecs.push_back(v(6'h05, 6'h00, 1, 1, '{busy: 1'b1, alu_op: 3'd1, default: '0}));
        vecs.push_back(v(6'h05, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h05, 6'h00, 0, 1, B));
        vecs.push_back(v(6'h05, 6'h00, 0, 1,
                         '{busy: 1'b1, alu_op: 3'd1, pc_we: 1'b1, pc_sel: 2'd1, default: '0}));
        // J after two fetch wait cycles, JAL, JR
        vecs.push_back(v(6'h02, 6'h00, 0, 0, F_WAIT));
        vecs.push_back(v(6'h02, 6'h00, 0, 0, F_WAIT));
        vecs.push_back(v(6'h02, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h02, 6'h00, 0, 1, '{busy: 1'b1, pc_we: 1'b1, pc_sel: 2'd2, default: '0}));
        vecs.push_back(v(6'h03, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h03, 6'h00, 0, 1, '{busy: 1'b1, pc_we: 1'b1, pc_sel: 2'd2, reg_we: 1'b1,
                                                 reg_dst: 2'd2, wb_sel: 2'd2, default: '0}));
        vecs.push_back(v(6'h00, 6'h08, 0, 1, F_RDY));
        vecs.push_back(v(6'h00, 6'h08, 0, 1, '{busy: 1'b1, pc_we: 1'b1, pc_sel: 2'd3, default: '0}));
        // Illegal opcode 0x3F -> HALT with fault 1
        vecs.push_back(v(6'h3F, 6'h00, 0, 1, F_RDY));
        vecs.push_back(v(6'h3F, 6'h00, 0, 1, B));
        vecs.push_back(v(6'h3F, 6'h00, 0, 1, '{fault: 2'd1, default: '0}));
        vecs.push_back(v(6'h3F, 6'h00, 0, 1, '{fault: 2'd1, default: '0}));

        @(negedge clk);
        do_reset(0);
        foreach (vecs[i]) step(vecs[i], i + 1);

        // Reset clears the sticky fault and restarts in FETCH.
        do_reset(100);
        step(v(6'h00, 6'h3F, 0, 0, F_WAIT), 101);
        step(v(6'h00, 6'h3F, 0, 1, F_RDY), 102);
        step(v(6'h00, 6'h3F, 0, 1, B), 103);
        step(v(6'h00, 6'h3F, 0, 1, '{fault: 2'd1, default: '0}), 104);

        // Fetch timeout: four waiting cycles then HALT with fault 2.
        do_reset(200);
        for (int i = 0; i < 4; i++) step(v(6'h00, 6'h20, 0, 0, F_WAIT), 201 + i);
        step(v(6'h00, 6'h20, 0, 1, '{fault: 2'd2, default: '0}), 205);

        // Ready on the limit cycle is still a success.
        do_reset(300);
        for (int i = 0; i < 3; i++) step(v(6'h00, 6'h20, 0, 0, F_WAIT), 301 + i);
        step(v(6'h00, 6'h20, 0, 1, F_RDY), 304);
        step(v(6'h00, 6'h20, 0, 1, B), 305);

        // Reset during a pending SW drops mem_we at once.
        step(v(6'h00, 6'h20, 0, 1, B), 306);
        step(v(6'h00, 6'h20, 0, 1, WB_RD), 307);
        step(v(6'h2B, 6'h00, 0, 1, F_RDY), 308);
        step(v(6'h2B, 6'h00, 0, 1, B), 309);
        step(v(6'h2B, 6'h00, 0, 1, EX_IMM), 310);
        step(v(6'h2B, 6'h00, 0, 0, '{busy: 1'b1, mem_we: 1'b1, mem_addr_sel: 1'b1, default: '0}), 311);
        do_reset(312);

`ifdef CTRL_PERF_EN
        for (int k = 0; k < 3; k++) begin
            step(v(6'h08, 6'h00, 0, 1, F_RDY), 400 + 4 * k);
            step(v(6'h08, 6'h00, 0, 1, B), 401 + 4 * k);
            step(v(6'h08, 6'h00, 0, 1, EX_IMM), 402 + 4 * k);
            step(v(6'h08, 6'h00, 0, 1, WB_RT), 403 + 4 * k);
        end
        #1;
        checks++;
        if (retired !== 32'd3) begin
            errors++;
            $display("FAIL retired_count: got %0d expected 3", retired);
        end else begin
            $display("retired_count ok: %0d", retired);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
